circuito_jogo_memoria: RTL and testbench

//  Top-level sequence-memory game ("Genius"). A fixed 16-entry sequence is replayed
//  by the player in growing rounds: round R requires entries 0..R.

---
 rtl/circuito_jogo_memoria_if.sv | 35 +++
 rtl/circuito_jogo_memoria.sv | 205 ++++++++++++++++++++
 tb/tb_circuito_jogo_memoria.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/circuito_jogo_memoria_if.sv
// Player-facing signal bundle of the sequence-memory game.
// The master side (board or bench) drives jogar and botoes.
// The slave side (the game core) drives the result flags and the debug displays.
interface circuito_jogo_memoria_if;
   logic       jogar;
   logic [3:0] botoes;
   logic [3:0] leds;
   logic       ganhou;
   logic       perdeu;
   logic       pronto;
   logic [6:0] db_contagem;
   logic [6:0] db_memoria;
   logic [6:0] db_estado;
   logic [6:0] db_jogadafeita;
   logic [6:0] db_rodada;
   logic       db_clock;
   logic       db_jogada_correta;
   logic       db_tem_jogada;
   logic       db_enderecoIgualRodada;
   logic       db_timeout;

   modport master (
      output jogar, botoes,
      input  leds, ganhou, perdeu, pronto,
      input  db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada,
      input  db_clock, db_jogada_correta, db_tem_jogada, db_enderecoIgualRodada, db_timeout
   );

   modport slave (
      input  jogar, botoes,
      output leds, ganhou, perdeu, pronto,
      output db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada,
      output db_clock, db_jogada_correta, db_tem_jogada, db_enderecoIgualRodada, db_timeout
   );
endinterface

// File: rtl/circuito_jogo_memoria.sv
// Sequence-memory game ("Genius") core.
// The player repeats a fixed 16-entry sequence in growing rounds: round R asks
// for entries 0..R. The game ends on a full win, a wrong button, or when no
// button is pressed for TIMEOUT_CYCLES clocks while the game waits for a play.
module circuito_jogo_memoria #(
   parameter int TIMEOUT_CYCLES = 150_000_000
) (
   input logic                     clock,
   input logic                     reset,
   circuito_jogo_memoria_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROX_JOGADA = 4'h6,
      PROX_RODADA = 4'h7,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   estado_t       r_estado;
   estado_t       w_proxEstado;

   logic [3:0]    r_rodada;
   logic [3:0]    r_contagem;
   logic [3:0]    r_jogada;
   logic [3:0]    r_botoesPrev;
   logic [TW-1:0] r_timer;

   logic          w_temJogada;
   logic          w_memoria;
   logic [3:0]    w_romDado;
   logic          w_jogadaCorreta;
   logic          w_enderecoIgualRodada;
   logic          w_timerFim;
   logic          w_limpaTudo;
   logic          w_registraJogada;
   logic          w_incTimer;
   logic          w_incContagem;
   logic          w_incRodada;

   // Fixed game sequence, one-hot per button.
   function automatic logic [3:0] romSequencia(input logic [3:0] endereco);
      case (endereco)
         4'd0:    romSequencia = 4'b0001;
         4'd1:    romSequencia = 4'b0010;
         4'd2:    romSequencia = 4'b0100;
         4'd3:    romSequencia = 4'b1000;
         4'd4:    romSequencia = 4'b0100;
         4'd5:    romSequencia = 4'b0010;
         4'd6:    romSequencia = 4'b0001;
         4'd7:    romSequencia = 4'b0001;
         4'd8:    romSequencia = 4'b0010;
         4'd9:    romSequencia = 4'b0010;
         4'd10:   romSequencia = 4'b0100;
         4'd11:   romSequencia = 4'b0100;
         4'd12:   romSequencia = 4'b1000;
         4'd13:   romSequencia = 4'b1000;
         4'd14:   romSequencia = 4'b0001;
         default: romSequencia = 4'b0100;
      endcase
   endfunction

   // Hex digit to active-low seven-segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex7seg(input logic [3:0] valor);
      case (valor)
         4'h0:    hex7seg = 7'h40;
         4'h1:    hex7seg = 7'h79;
         4'h2:    hex7seg = 7'h24;
         4'h3:    hex7seg = 7'h30;
         4'h4:    hex7seg = 7'h19;
         4'h5:    hex7seg = 7'h12;
         4'h6:    hex7seg = 7'h02;
         4'h7:    hex7seg = 7'h78;
         4'h8:    hex7seg = 7'h00;
         4'h9:    hex7seg = 7'h10;
         4'hA:    hex7seg = 7'h08;
         4'hB:    hex7seg = 7'h03;
         4'hC:    hex7seg = 7'h46;
         4'hD:    hex7seg = 7'h21;
         4'hE:    hex7seg = 7'h06;
         default: hex7seg = 7'h0E;
      endcase
   endfunction

   // A press is the rising edge of "any button down"; holding a button counts once.
   assign w_temJogada           = (|bus.botoes) & ~(|r_botoesPrev);
   assign w_romDado             = romSequencia(r_contagem);
   assign w_memoria             = (r_jogada == w_romDado);
   assign w_jogadaCorreta       = w_memoria;
   assign w_enderecoIgualRodada = (r_contagem == r_rodada);
   assign w_timerFim            = (r_timer == TIMER_LAST);

   // State register; reset is synchronous and beats any pending transition.
   always_ff @(posedge clock) begin
      if (reset) r_estado <= INICIAL;
      else       r_estado <= w_proxEstado;
   end

   // Next-state decision plus the one-cycle datapath strobes for each state.
   always_comb begin
      w_proxEstado     = r_estado;
      w_limpaTudo      = 1'b0;
      w_registraJogada = 1'b0;
      w_incTimer       = 1'b0;
      w_incContagem    = 1'b0;
      w_incRodada      = 1'b0;
      case (r_estado)
         INICIAL: begin
            if (bus.jogar) w_proxEstado = PREPARA;
         end
         PREPARA: begin
            w_limpaTudo  = 1'b1;
            w_proxEstado = ESPERA;
         end
         ESPERA: begin
            if (w_temJogada) begin
               w_registraJogada = 1'b1;
               w_proxEstado     = REGISTRA;
            end else if (w_timerFim) begin
               w_proxEstado = FIM_TIMEOUT;
            end else begin
               w_incTimer = 1'b1;
            end
         end
         REGISTRA: begin
            w_proxEstado = COMPARA;
         end
         COMPARA: begin
            if (!w_jogadaCorreta)            w_proxEstado = FIM_ERRO;
            else if (!w_enderecoIgualRodada) w_proxEstado = PROX_JOGADA;
            else if (r_rodada == 4'hF)       w_proxEstado = FIM_ACERTO;
            else                             w_proxEstado = PROX_RODADA;
         end
         PROX_JOGADA: begin
            w_incContagem = 1'b1;
            w_proxEstado  = ESPERA;
         end
         PROX_RODADA: begin
            w_incRodada  = 1'b1;
            w_proxEstado = ESPERA;
         end
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (bus.jogar) w_proxEstado = PREPARA;
         end
         default: begin
            w_proxEstado = INICIAL;
         end
      endcase
   end

   // Datapath: round/play counters, play register, idle timer and press-edge history.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rodada     <= 4'd0;
         r_contagem   <= 4'd0;
         r_jogada     <= 4'd0;
         r_timer      <= '0;
         r_botoesPrev <= 4'd0;
      end else begin
         r_botoesPrev <= bus.botoes;
         if (w_limpaTudo) begin
            r_rodada   <= 4'd0;
            r_contagem <= 4'd0;
            r_jogada   <= 4'd0;
            r_timer    <= '0;
         end
         if (w_registraJogada) begin
            r_jogada <= bus.botoes;
            r_timer  <= '0;
         end
         if (w_incTimer)    r_timer    <= r_timer + TW'(1);
         if (w_incContagem) r_contagem <= r_contagem + 4'd1;
         if (w_incRodada) begin
            r_rodada   <= r_rodada + 4'd1;
            r_contagem <= 4'd0;
            r_timer    <= '0;
         end
      end
   end

   assign bus.leds                   = r_jogada;
   assign bus.ganhou                 = (r_estado == FIM_ACERTO);
   assign bus.perdeu                 = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
   assign bus.pronto                 = bus.ganhou || bus.perdeu;
   assign bus.db_contagem            = hex7seg(r_contagem);
   assign bus.db_memoria             = hex7seg(w_romDado);
   assign bus.db_estado              = hex7seg(r_estado);
   assign bus.db_jogadafeita         = hex7seg(r_jogada);
   assign bus.db_rodada              = hex7seg(r_rodada);
   assign bus.db_clock               = clock;
   assign bus.db_jogada_correta      = w_jogadaCorreta;
   assign bus.db_tem_jogada          = w_temJogada;
   assign bus.db_enderecoIgualRodada = w_enderecoIgualRodada;
   assign bus.db_timeout             = w_timerFim;

endmodule

// File: tb/tb_circuito_jogo_memoria.sv
// Directed bench for the sequence-memory game: reset state, round progression,
// press-to-result latency, idle timeout, wrong button, full win and restart.
// The idle limit is shortened so the timeout path runs in a few dozen cycles.
module tb_circuito_jogo_memoria;

   localparam int TIMEOUT = 40;

   logic clock;
   logic reset;
   int   compared;
   int   mismatched;

   logic [6:0] segTable [16];
   logic [3:0] romModel [16];

   circuito_jogo_memoria_if bus ();

   circuito_jogo_memoria #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One comparison: counts it, and on a miss counts the failure and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One press: button held five cycles, then released five cycles.
   task automatic applyStimulus(input logic [3:0] botao);
      bus.botoes = botao;
      repeat (5) @(negedge clock);
      bus.botoes = 4'b0000;
      repeat (5) @(negedge clock);
   endtask

   // Hold jogar for the given number of cycles.
   task automatic pulseJogar(input int ciclos);
      bus.jogar = 1'b1;
      repeat (ciclos) @(negedge clock);
      bus.jogar = 1'b0;
      @(negedge clock);
   endtask

   // Directed stimulus sequence with hand-derived expectations.
   initial begin
      compared   = 0;
      mismatched = 0;
      segTable   = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      romModel   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                     4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
      reset      = 1'b1;
      bus.jogar  = 1'b0;
      bus.botoes = 4'b0000;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      $display("[TB] reset and idle");
      checkOutput("rstGanhou",   bus.ganhou, 1'b0);
      checkOutput("rstPerdeu",   bus.perdeu, 1'b0);
      checkOutput("rstPronto",   bus.pronto, 1'b0);
      checkOutput("rstEstado",   bus.db_estado, segTable[0]);
      checkOutput("rstLeds",     bus.leds, 4'b0000);
      checkOutput("rstTimeout",  bus.db_timeout, 1'b0);
      checkOutput("rstTemJog",   bus.db_tem_jogada, 1'b0);
      checkOutput("rstCorreta",  bus.db_jogada_correta, 1'b0);
      checkOutput("rstRodada",   bus.db_rodada, segTable[0]);

      $display("[TB] start game and play round 0");
      pulseJogar(5);
      checkOutput("startEstado", bus.db_estado, segTable[2]);
      checkOutput("startMem",    bus.db_memoria, segTable[1]);
      bus.botoes = 4'b0001;
      #1;
      checkOutput("pressPulse",  bus.db_tem_jogada, 1'b1);
      @(negedge clock);
      checkOutput("latRegistra", bus.db_estado, segTable[4]);
      checkOutput("heldNoPulse", bus.db_tem_jogada, 1'b0);
      checkOutput("latchLeds",   bus.leds, 4'b0001);
      @(negedge clock);
      checkOutput("latCompara",  bus.db_estado, segTable[5]);
      checkOutput("corretaR0",   bus.db_jogada_correta, 1'b1);
      @(negedge clock);
      checkOutput("latProxRod",  bus.db_estado, segTable[7]);
      repeat (2) @(negedge clock);
      bus.botoes = 4'b0000;
      repeat (5) @(negedge clock);
      checkOutput("r0Rodada",    bus.db_rodada, segTable[1]);
      checkOutput("r0Contagem",  bus.db_contagem, segTable[0]);
      checkOutput("r0Perdeu",    bus.perdeu, 1'b0);
      checkOutput("r0Estado",    bus.db_estado, segTable[2]);

      $display("[TB] rounds 1 and 2");
      applyStimulus(4'b0001);
      checkOutput("r1e1Contagem", bus.db_contagem, segTable[1]);
      checkOutput("r1e1Rodada",   bus.db_rodada, segTable[1]);
      applyStimulus(4'b0010);
      checkOutput("r1Rodada",     bus.db_rodada, segTable[2]);
      checkOutput("r1Contagem",   bus.db_contagem, segTable[0]);
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      checkOutput("r2e2Contagem", bus.db_contagem, segTable[2]);
      applyStimulus(4'b0100);
      checkOutput("r2Rodada",     bus.db_rodada, segTable[3]);
      checkOutput("r2Perdeu",     bus.perdeu, 1'b0);

      $display("[TB] round 3 idle timeout");
      applyStimulus(4'b0001);
      checkOutput("r3e1Contagem", bus.db_contagem, segTable[1]);
      repeat (20) @(negedge clock);
      checkOutput("preTimeoutEst", bus.db_estado, segTable[2]);
      checkOutput("preTimeoutFlg", bus.db_timeout, 1'b0);
      repeat (30) @(negedge clock);
      checkOutput("toEstado",  bus.db_estado, segTable[13]);
      checkOutput("toPerdeu",  bus.perdeu, 1'b1);
      checkOutput("toPronto",  bus.pronto, 1'b1);
      checkOutput("toFlag",    bus.db_timeout, 1'b1);
      checkOutput("toGanhou",  bus.ganhou, 1'b0);
      applyStimulus(4'b0010);
      checkOutput("toIgnEstado", bus.db_estado, segTable[13]);
      checkOutput("toIgnLeds",   bus.leds, 4'b0001);

      $display("[TB] wrong button");
      pulseJogar(5);
      checkOutput("restartEstado", bus.db_estado, segTable[2]);
      checkOutput("restartRodada", bus.db_rodada, segTable[0]);
      checkOutput("restartLeds",   bus.leds, 4'b0000);
      applyStimulus(4'b0001);
      applyStimulus(4'b0001);
      checkOutput("errMem",     bus.db_memoria, segTable[2]);
      applyStimulus(4'b0100);
      checkOutput("errEstado",  bus.db_estado, segTable[14]);
      checkOutput("errPerdeu",  bus.perdeu, 1'b1);
      checkOutput("errPronto",  bus.pronto, 1'b1);
      checkOutput("errGanhou",  bus.ganhou, 1'b0);
      checkOutput("errCorreta", bus.db_jogada_correta, 1'b0);
      checkOutput("errLeds",    bus.leds, 4'b0100);

      $display("[TB] full winning game");
      pulseJogar(5);
      for (int r = 0; r < 16; r++) begin
         for (int e = 0; e <= r; e++) applyStimulus(romModel[e]);
         if (r < 15) checkOutput("winRodada", bus.db_rodada, segTable[r + 1]);
      end
      checkOutput("winEstado",  bus.db_estado, segTable[10]);
      checkOutput("winGanhou",  bus.ganhou, 1'b1);
      checkOutput("winPronto",  bus.pronto, 1'b1);
      checkOutput("winPerdeu",  bus.perdeu, 1'b0);
      checkOutput("winRodadaF", bus.db_rodada, segTable[15]);
      checkOutput("winIgual",   bus.db_enderecoIgualRodada, 1'b1);

      $display("[TB] restart after win");
      bus.jogar = 1'b1;
      @(negedge clock);
      checkOutput("rePrepara",  bus.db_estado, segTable[1]);
      checkOutput("reGanhou",   bus.ganhou, 1'b0);
      repeat (9) @(negedge clock);
      bus.jogar = 1'b0;
      @(negedge clock);
      checkOutput("reEstado",   bus.db_estado, segTable[2]);
      checkOutput("reRodada",   bus.db_rodada, segTable[0]);
      checkOutput("reContagem", bus.db_contagem, segTable[0]);

      $display("[TB] reset mid-game");
      applyStimulus(4'b0001);
      checkOutput("midRodada", bus.db_rodada, segTable[1]);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midRstEstado", bus.db_estado, segTable[0]);
      checkOutput("midRstLeds",   bus.leds, 4'b0000);
      checkOutput("midRstRodada", bus.db_rodada, segTable[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
